dmem_responder: RTL



---
 rtl/dmem_responder.sv | 96 +++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: synchronous-read 32-bit RAM with byte-lane writes and a display read port.
// Define DMEM_CLEAR_EN to include the post-reset clearing engine (CLEAR sweep before dm_ready).
module dmem_responder #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_wen,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  input  logic [31:0] test_addr,
  output logic [31:0] test_data
);

  // state    | meaning
  // ST_INIT  | clearing sweep (DMEM_CLEAR_EN) or one settle cycle after reset; accesses ignored
  // ST_READY | array usable; reads and lane writes serviced every edge, terminal until reset

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            state, state_nxt;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx, test_idx;
  logic              acc_en;
  logic              unused_addr_bits;

  assign idx      = dm_addr[ADDR_W+1:2];
  assign test_idx = test_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{dm_addr[31:ADDR_W+2], dm_addr[1:0],
                              test_addr[31:ADDR_W+2], test_addr[1:0]};

`ifdef DMEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_idx;
  logic              clr_en;
  logic              clr_last;

  assign clr_last = (clr_idx == {ADDR_W{1'b1}});

  // Wraps back to 0 on the final clear and then stays put in ST_READY.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     clr_idx <= '0;
    else if (clr_en) clr_idx <= clr_idx + 1'b1;
  end
`endif

  always_comb begin
    state_nxt = state;
    acc_en    = 1'b0;
`ifdef DMEM_CLEAR_EN
    clr_en    = 1'b0;
`endif
    case (state)
      ST_INIT: begin
`ifdef DMEM_CLEAR_EN
        clr_en = 1'b1;
        if (clr_last) state_nxt = ST_READY;
`else
        state_nxt = ST_READY;
`endif
      end
      ST_READY: acc_en = 1'b1;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_INIT;
      dm_ready  <= 1'b0;
      dm_rdata  <= '0;
      test_data <= '0;
    end else begin
      state    <= state_nxt;
      dm_ready <= (state_nxt == ST_READY);
      if (acc_en) dm_rdata <= mem[idx];
      test_data <= mem[test_idx];
    end
  end

  // Array has no reset; both read registers above sample the pre-write word (read-first).
  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
    if (clr_en) mem[clr_idx] <= '0;
`endif
    if (acc_en) begin
      for (int i = 0; i < 4; i++) begin
        if (dm_wen[i]) mem[idx][8*i +: 8] <= dm_wdata[8*i +: 8];
      end
    end
  end

endmodule
